ex_mdu: RTL
===========

// Module: ex_mdu
// PURPOSE
//  Multi-cycle multiply/divide unit with HI/LO registers, sitting beside the ALU in the EX stage.
//  Accepts one operation per start pulse from EX and holds the result in pending registers.
//  Commits HI/LO after a parametrised latency and raises busy/stall for the hazard unit.
//  Honours precise exceptions: EX-stage exceptions and flush cancel the op; an in-flight op completes.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   cycles from accepted MULT/MULTU to HI/LO commit (>=1)
//  DIV_CYCLES   10  cycles from accepted DIV/DIVU to HI/LO commit (>=1)
// PORTS
//  clk        in   1       single clock; all state changes on rising edge
//  reset      in   1       synchronous, active-low (0 = reset), sampled on clk rising edge
//  start      in   1       EX instruction is an MDU op (decoded by ctrl)
//  mdu_op     in   4       operation code, encodings in mdu_defs.vh
//  src_a      in   WIDTH   forwarded rs value
//  src_b      in   WIDTH   forwarded rt value
//  cancel     in   1       EX instr has an exception (ExcCode!=0) or pipeline flush; op must have no effect
//  busy       out  1       multi-cycle op in flight (registered)
//  stall_req  out  1       = busy | (start & op is MULT/DIV/MTHI/MTLO/MFHI/MFLO & busy); to hazard unit
//  hi         out  WIDTH   architectural HI
//  lo         out  WIDTH   architectural LO
// BEHAVIOUR
//  Reset (reset==0 at edge): hi=0, lo=0, busy=0, counter=0, pending=0; any in-flight op discarded.
//  Accept: start & ~cancel & ~busy at edge t. Ops ignored when cancel=1 or busy=1 (EX is stalled).
//  MULT/MULTU: {HI,LO} = signed/unsigned 2*WIDTH product of src_a*src_b; operands latched at t.
//  DIV/DIVU: LO=quotient, HI=remainder, signed truncates toward zero, remainder takes dividend sign.
//  Divide by zero: op accepted, busy for DIV_CYCLES, HI/LO left unchanged at commit.
//  Signed DIV of -2^(WIDTH-1) by -1: LO=-2^(WIDTH-1), HI=0, no exception.
//  Latency: busy=1 for cycles t+1..t+N (N=MULT_CYCLES or DIV_CYCLES); HI/LO show new value from t+N+1.
//  Counter: loads N at accept, decrements while busy; commit happens on the edge where it goes 1->0.
//  MTHI/MTLO: single cycle, hi/lo updated at edge t, no busy; suppressed by cancel.
//  MFHI/MFLO: read-only via hi/lo outputs; stall_req holds EX while busy.
//  Any MDU op arriving while busy: stall_req=1, not accepted until busy falls; src re-sampled then.
//  cancel with no in-flight op: no state change. cancel never aborts an already accepted op
//  (it belongs to an older instr that has already left EX).
//  Reset mid-operation wins over commit in the same cycle.
//  Invalid mdu_op with start: treated as NOP, no busy.
// CONFIGURATION
//  MDU_MADD_EN defined: adds MADD/MADDU/MSUB/MSUBU; {HI,LO} +/-= product, commit after MULT_CYCLES;
//    accumulation uses HI/LO value at commit (ops serialised by busy, so identical to value at accept).
//  MDU_MADD_EN undefined: those encodings decode as invalid -> NOP; no accumulator adder synthesised.
// STRUCTURE
//  mdu_defs.vh: MDU_OP_* localparams (NOP,MULT,MULTU,DIV,DIVU,MTHI,MTLO,MFHI,MFLO,MADD,MADDU,MSUB,MSUBU).
//  Sub-module mdu_divider: combinational signed/unsigned quotient/remainder incl. zero/overflow cases.
//  Top holds counter, pending {hi,lo}, op class, commit mux; product uses $signed/unsigned 2*WIDTH mult.
// TESTING
//  MULT src_a=-3 src_b=7 -> busy 5 cycles, then hi=FFFFFFFF lo=FFFFFFEB.
//  DIVU 100/7 -> busy 10 cycles, then lo=14 hi=2; DIV -7/2 -> lo=FFFFFFFD hi=FFFFFFFF.
//  DIV 5/0 after MTHI 0xAA, MTLO 0xBB -> busy 10 cycles, hi=AA lo=BB unchanged.
//  MULT with cancel=1 -> busy stays 0, hi/lo unchanged; MTLO 0x55 with cancel=1 -> lo unchanged.
//  MULTU during busy DIV -> stall_req=1 until DIV commits, then MULTU accepted with current srcs.
//  reset=0 at 3rd busy cycle of DIV -> next cycle busy=0 hi=0 lo=0; with MDU_MADD_EN: hi=0 lo=10, MADD 2*3 -> lo=16.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings and commit classes.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package ex_mdu_pkg;

  localparam logic [3:0] MDU_OP_NOP   = 4'd0;
  localparam logic [3:0] MDU_OP_MULT  = 4'd1;
  localparam logic [3:0] MDU_OP_MULTU = 4'd2;
  localparam logic [3:0] MDU_OP_DIV   = 4'd3;
  localparam logic [3:0] MDU_OP_DIVU  = 4'd4;
  localparam logic [3:0] MDU_OP_MTHI  = 4'd5;
  localparam logic [3:0] MDU_OP_MTLO  = 4'd6;
  localparam logic [3:0] MDU_OP_MFHI  = 4'd7;
  localparam logic [3:0] MDU_OP_MFLO  = 4'd8;
  localparam logic [3:0] MDU_OP_MADD  = 4'd9;
  localparam logic [3:0] MDU_OP_MADDU = 4'd10;
  localparam logic [3:0] MDU_OP_MSUB  = 4'd11;
  localparam logic [3:0] MDU_OP_MSUBU = 4'd12;

  // What the commit edge does with the pending {hi,lo}.
  typedef enum logic [2:0] {
    ClsNone,
    ClsMul,
    ClsDiv,
    ClsHold,
    ClsMadd,
    ClsMsub
  } op_cls_e;

  function automatic logic is_mdu_op(input logic [3:0] op);
    case (op)
      MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU,
      MDU_OP_MTHI, MDU_OP_MTLO, MDU_OP_MFHI, MDU_OP_MFLO: return 1'b1;
`ifdef MDU_MADD_EN
      MDU_OP_MADD, MDU_OP_MADDU, MDU_OP_MSUB, MDU_OP_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_mdu_divider.sv
// Combinational signed/unsigned divider; flags divide-by-zero and pins the
// most-negative / -1 overflow case to quotient = dividend, remainder = 0.
module ex_mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  logic             overflow;
  logic [WIDTH-1:0] safe_divisor;
  logic signed [WIDTH-1:0] s_dividend, s_divisor;

  assign div_zero     = (divisor == '0);
  assign overflow     = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (divisor == {WIDTH{1'b1}});
  // Keep the operator away from a zero divisor so the result is never X.
  assign safe_divisor = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : divisor;
  assign s_dividend   = $signed(dividend);
  assign s_divisor    = $signed(safe_divisor);

  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (overflow) begin
      quotient  = dividend;
      remainder = '0;
    end else if (is_signed) begin
      quotient  = $unsigned(s_dividend / s_divisor);
      remainder = $unsigned(s_dividend % s_divisor);
    end else begin
      quotient  = dividend / safe_divisor;
      remainder = dividend % safe_divisor;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// EX-stage multi-cycle multiply/divide unit with HI/LO registers and hazard stall request.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate operations.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       mdu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MulCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] OneCnt = CntW'(1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  op_cls_e          cls_q, cls_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, product;
  logic [WIDTH-1:0]   quotient, remainder;
  logic               div_zero;

  assign mul_signed = (mdu_op == MDU_OP_MULT) || (mdu_op == MDU_OP_MADD) ||
                      (mdu_op == MDU_OP_MSUB);
  // Sign/zero extension lets one 2*WIDTH multiplier serve both signednesses.
  assign ext_a   = {{WIDTH{mul_signed & src_a[WIDTH-1]}}, src_a};
  assign ext_b   = {{WIDTH{mul_signed & src_b[WIDTH-1]}}, src_b};
  assign product = ext_a * ext_b;

  ex_mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .dividend (src_a),
    .divisor  (src_b),
    .is_signed(mdu_op == MDU_OP_DIV),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  assign busy      = (cnt_q != '0);
  assign stall_req = busy | (start & is_mdu_op(mdu_op) & busy);
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    cnt_d     = cnt_q;
    cls_d     = cls_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (busy) begin
      cnt_d = cnt_q - OneCnt;
      if (cnt_q == OneCnt) begin
        case (cls_q)
          ClsMul, ClsDiv: begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
`ifdef MDU_MADD_EN
          ClsMadd: {hi_d, lo_d} = {hi_q, lo_q} + {pend_hi_q, pend_lo_q};
          ClsMsub: {hi_d, lo_d} = {hi_q, lo_q} - {pend_hi_q, pend_lo_q};
`endif
          default: ;
        endcase
      end
    end else if (start && !cancel) begin
      case (mdu_op)
        MDU_OP_MULT, MDU_OP_MULTU: begin
          cnt_d                  = MulCnt;
          cls_d                  = ClsMul;
          {pend_hi_d, pend_lo_d} = product;
        end
        MDU_OP_DIV, MDU_OP_DIVU: begin
          cnt_d     = DivCnt;
          cls_d     = div_zero ? ClsHold : ClsDiv;
          pend_hi_d = remainder;
          pend_lo_d = quotient;
        end
        MDU_OP_MTHI: hi_d = src_a;
        MDU_OP_MTLO: lo_d = src_a;
`ifdef MDU_MADD_EN
        MDU_OP_MADD, MDU_OP_MADDU: begin
          cnt_d                  = MulCnt;
          cls_d                  = ClsMadd;
          {pend_hi_d, pend_lo_d} = product;
        end
        MDU_OP_MSUB, MDU_OP_MSUBU: begin
          cnt_d                  = MulCnt;
          cls_d                  = ClsMsub;
          {pend_hi_d, pend_lo_d} = product;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      cls_q     <= ClsNone;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule
